// File: rtl/gpr_fwd_scoreboard.sv
// ID-stage forwarding-select and load-use/divider interlock scoreboard.
// Tracks GPR writers in EX, MEM1 and MEM2 plus the divider busy count.
module gpr_fwd_scoreboard #(
    parameter int DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pipe_stall,
    input  logic       flush,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wr_en,
    input  logic [4:0] id_wr_addr,
    input  logic [1:0] id_rdy_stg,
    input  logic       id_div_start,
    input  logic       id_use_hilo,
    output logic [1:0] MUX4Sel,
    output logic [1:0] MUX5Sel,
    output logic       stall_id,
    output logic       div_busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef struct packed {
        logic       vld;
        logic [4:0] addr;
        logic [1:0] rdy;
    } ent_t;

    ent_t          e_ex;
    ent_t          e_mem1;
    ent_t          e_mem2;
    ent_t          id_ent;
    logic [CW-1:0] div_cnt;

    logic          rs_chk;
    logic          rt_chk;
    logic          rs_haz;
    logic          rt_haz;
    logic          id_cap;
    logic          div_load;

    // Returns {hazard, select}; youngest matching stage decides.
    function automatic logic [2:0] fwd(
        input ent_t       ex,
        input ent_t       m1,
        input ent_t       m2,
        input logic [4:0] src
    );
        logic [2:0] r;
        r = 3'b000;
        if (ex.vld && ex.addr == src) begin
            r = (ex.rdy == 2'd0) ? 3'b001 : 3'b100;
        end else if (m1.vld && m1.addr == src) begin
            r = (m1.rdy <= 2'd1) ? 3'b010 : 3'b100;
        end else if (m2.vld && m2.addr == src) begin
            r = (m2.rdy <= 2'd2) ? 3'b011 : 3'b100;
        end
        return r;
    endfunction

    always_comb begin
        rs_chk = id_valid && id_use_rs && (id_rs != 5'd0);
        rt_chk = id_valid && id_use_rt && (id_rt != 5'd0);
        {rs_haz, MUX4Sel} = rs_chk ? fwd(e_ex, e_mem1, e_mem2, id_rs) : 3'b000;
        {rt_haz, MUX5Sel} = rt_chk ? fwd(e_ex, e_mem1, e_mem2, id_rt) : 3'b000;
        div_busy = (div_cnt != '0);
        stall_id = id_valid && (rs_haz || rt_haz || (id_use_hilo && div_busy));
    end

    // r0 is stored invalid; a ready stage of 3 means MEM2.
    always_comb begin
        id_ent.vld  = id_wr_en && (id_wr_addr != 5'd0);
        id_ent.addr = id_wr_addr;
        id_ent.rdy  = (id_rdy_stg == 2'd3) ? 2'd2 : id_rdy_stg;
        id_cap      = id_valid && id_wr_en && !stall_id;
        div_load    = id_div_start && id_valid && !stall_id && !pipe_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ex    <= '0;
            e_mem1  <= '0;
            e_mem2  <= '0;
            div_cnt <= '0;
        end else if (flush) begin
            e_ex    <= '0;
            e_mem1  <= '0;
            e_mem2  <= '0;
            div_cnt <= '0;
        end else begin
            if (!pipe_stall) begin
                e_mem2 <= e_mem1;
                e_mem1 <= e_ex;
                e_ex   <= id_cap ? id_ent : '0;
            end
            // Divider keeps counting through global freezes.
            if (div_load) begin
                div_cnt <= CW'(DIV_CYCLES);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpr_fwd_scoreboard.sv
// Directed table-driven bench for gpr_fwd_scoreboard (DIV_CYCLES=4).
// Each vector is one ID cycle; outputs are checked mid-cycle.
module tb_gpr_fwd_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       pipe_stall;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wr_en;
    logic [4:0] id_wr_addr;
    logic [1:0] id_rdy_stg;
    logic       id_div_start;
    logic       id_use_hilo;
    logic [1:0] MUX4Sel;
    logic [1:0] MUX5Sel;
    logic       stall_id;
    logic       div_busy;

    int ncmp;
    int nfail;

    gpr_fwd_scoreboard #(.DIV_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_wr_en     (id_wr_en),
        .id_wr_addr   (id_wr_addr),
        .id_rdy_stg   (id_rdy_stg),
        .id_div_start (id_div_start),
        .id_use_hilo  (id_use_hilo),
        .MUX4Sel      (MUX4Sel),
        .MUX5Sel      (MUX5Sel),
        .stall_id     (stall_id),
        .div_busy     (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       ps;
        logic       fl;
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wen;
        logic [4:0] wa;
        logic [1:0] rdy;
        logic       ds;
        logic       uh;
        logic [1:0] m4;
        logic [1:0] m5;
        logic       st;
        logic       bz;
    } vec_t;

    function automatic vec_t v(
        string nm,
        logic ps, logic fl, logic vld,
        logic [4:0] rs, logic [4:0] rt,
        logic urs, logic urt,
        logic wen, logic [4:0] wa, logic [1:0] rdy,
        logic ds, logic uh,
        logic [1:0] m4, logic [1:0] m5,
        logic st, logic bz
    );
        vec_t r;
        r.nm = nm; r.ps = ps; r.fl = fl; r.vld = vld;
        r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.wen = wen; r.wa = wa; r.rdy = rdy;
        r.ds = ds; r.uh = uh;
        r.m4 = m4; r.m5 = m5; r.st = st; r.bz = bz;
        return r;
    endfunction

    task automatic chk(string nm, logic [1:0] m4, logic [1:0] m5,
                       logic st, logic bz);
        ncmp++;
        if (MUX4Sel !== m4) begin
            nfail++;
            $display("FAIL %s MUX4Sel got %b want %b", nm, MUX4Sel, m4);
        end
        ncmp++;
        if (MUX5Sel !== m5) begin
            nfail++;
            $display("FAIL %s MUX5Sel got %b want %b", nm, MUX5Sel, m5);
        end
        ncmp++;
        if (stall_id !== st) begin
            nfail++;
            $display("FAIL %s stall_id got %b want %b", nm, stall_id, st);
        end
        ncmp++;
        if (div_busy !== bz) begin
            nfail++;
            $display("FAIL %s div_busy got %b want %b", nm, div_busy, bz);
        end
    endtask

    task automatic drive(vec_t x);
        pipe_stall   = x.ps;
        flush        = x.fl;
        id_valid     = x.vld;
        id_rs        = x.rs;
        id_rt        = x.rt;
        id_use_rs    = x.urs;
        id_use_rt    = x.urt;
        id_wr_en     = x.wen;
        id_wr_addr   = x.wa;
        id_rdy_stg   = x.rdy;
        id_div_start = x.ds;
        id_use_hilo  = x.uh;
    endtask

    task automatic run(vec_t x);
        drive(x);
        @(negedge clk);
        chk(x.nm, x.m4, x.m5, x.st, x.bz);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[26];
    vec_t q;

    initial begin
        ncmp  = 0;
        nfail = 0;
        //          name          ps fl vd rs rt ur ut we wa rd ds uh  m4 m5 st bz
        tbl[0]  = v("t1_addu_r3",  0, 0, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v("t1_fwd_ex",   0, 0, 1, 3, 0, 1, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0);
        tbl[2]  = v("t1_fwd_mem1", 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        tbl[3]  = v("t1_fwd_mem2", 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        tbl[4]  = v("t1_retired",  0, 0, 1, 3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        tbl[5]  = v("t2_lw_r5",    0, 0, 1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0);
        tbl[6]  = v("t2_lu_ex",    0, 0, 1, 0, 5, 0, 1, 1, 6, 0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = v("t2_lu_mem1",  0, 0, 1, 0, 5, 0, 1, 1, 6, 0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = v("t2_fwd_mem2", 0, 0, 1, 0, 5, 0, 1, 1, 6, 0, 0, 0, 0, 3, 0, 0);
        tbl[9]  = v("flush_cyc",   0, 1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[10] = v("flushed",     0, 0, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = v("t3_wr_r0",    0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        tbl[12] = v("t3_r0_ex",    0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = v("t3_r0_mem1",  0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = v("t4_addu_r7",  0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = v("t4_ori_r7",   0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = v("t4_young_ex", 0, 0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        tbl[17] = v("t4_no_use",   0, 0, 1, 7, 7, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = v("t4_lw_r7",    0, 0, 1, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 0, 0, 0);
        tbl[19] = v("t4_ex_nrdy",  0, 0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[20] = v("t4_m1_nrdy",  0, 0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[21] = v("t4_m2_fwd",   0, 0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        tbl[22] = v("rdy3_lw_r9",  0, 0, 1, 0, 0, 0, 0, 1, 9, 3, 0, 0, 0, 0, 0, 0);
        tbl[23] = v("id_invalid",  0, 0, 0, 9, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = v("rdy3_mem1",   0, 0, 1, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[25] = v("rdy3_mem2",   0, 0, 1, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);

        rst_n = 1'b0;
        drive(v("rst", 0, 0, 1, 3, 5, 1, 1, 1, 3, 0, 1, 1, 0, 0, 0, 0));
        #3;
        chk("reset", 2'd0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i]);

        // divider interlock, including frozen cycles, then flush abort
        run(v("t5_div",      0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        run(v("t5_mfhi_1",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        run(v("t5_mfhi_2ps", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        run(v("t5_mfhi_3ps", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        run(v("t5_mfhi_4",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        run(v("t5_mfhi_go",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run(v("t5_div2",     0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        run(v("t5_flush",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
        run(v("t5_aborted",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        run(v("t5_div_ps",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        run(v("t5_no_load",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // load-use held through a freeze, then async reset mid-stream
        run(v("t6_lw_r5",    0, 0, 1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0));
        run(v("t6_hold_1",   1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        run(v("t6_hold_2",   1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        run(v("t6_hold_3",   1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        run(v("t6_still_ex", 0, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        run(v("t6_addu_div", 0, 0, 1, 0, 0, 0, 0, 1, 8, 0, 1, 1, 0, 0, 0, 0));

        q = v("t6_pre_rst",  0, 0, 1, 8, 5, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1);
        drive(q);
        @(negedge clk);
        chk(q.nm, q.m4, q.m5, q.st, q.bz);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", 2'd0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(v("t6_post_rst", 0, 0, 1, 8, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
